// File: rtl/servo_dispense_scheduler.sv
// servo_dispense_scheduler: queues vend requests and sequences one servo at a
// time through vend -> hold -> return, while driving frame-aligned PWM on all
// servo channels. Idle channels always carry the home pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req_valid/id    vend request handshake (accepted when req_ready)
//   req_ready       request FIFO has space
//   servo_out       registered PWM, one bit per servo
//   busy            a vend cycle is in progress (VEND or RETURN)
//   active_id       servo being sequenced; holds its last value when idle
//   done_pulse/id   one-cycle strobe at the end of a vend cycle
//   err_pulse       one-cycle strobe when an out-of-range id is discarded
//   fifo_count      number of queued requests
module servo_dispense_scheduler #(
    parameter int unsigned NUM_SERVOS    = 4,
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned PULSE_HOME    = 50000,
    parameter int unsigned PULSE_VEND    = 100000,
    parameter int unsigned HOLD_FRAMES   = 25,
    parameter int unsigned RETURN_FRAMES = 25,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [2:0]            req_id,
    output logic                  req_ready,
    output logic [NUM_SERVOS-1:0] servo_out,
    output logic                  busy,
    output logic [2:0]            active_id,
    output logic                  done_pulse,
    output logic [2:0]            done_id,
    output logic                  err_pulse,
    output logic [2:0]            fifo_count
);
    localparam int unsigned ID_W   = 3;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned FC_W   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned MAX_FR = (HOLD_FRAMES > RETURN_FRAMES) ? HOLD_FRAMES : RETURN_FRAMES;
    localparam int unsigned FR_W   = (MAX_FR > 1) ? $clog2(MAX_FR) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_RETURN = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [FR_W-1:0]     fcnt, fcnt_d;
    logic [ID_W-1:0]     active_d, done_id_d;
    logic                done_d, err_d;

    logic [FC_W-1:0]     frame_cnt;
    logic                frame_end;

    logic [ID_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count_d;
    logic [ID_W-1:0]     head_id;
    logic                head_valid;
    logic                push, pop;

    logic [FC_W-1:0]     pulse_w [NUM_SERVOS];

    assign frame_end  = (frame_cnt == FC_W'(PERIOD_CYCLES - 1));
    assign push       = req_valid && req_ready;
    assign head_id    = fifo_mem[rd_ptr];
    assign head_valid = (32'(head_id) < NUM_SERVOS);

    // Next-state logic; every transition (and every pop) happens on the frame boundary.
    always_comb begin
        state_d   = state;
        fcnt_d    = fcnt;
        active_d  = active_id;
        done_d    = 1'b0;
        done_id_d = done_id;
        err_d     = 1'b0;
        pop       = 1'b0;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (fifo_count != '0) begin
                        pop = 1'b1;
                        if (head_valid) begin
                            state_d  = S_VEND;
                            active_d = head_id;
                            fcnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_VEND: begin
                    if (fcnt == FR_W'(HOLD_FRAMES - 1)) begin
                        state_d = S_RETURN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt + FR_W'(1);
                    end
                end
                S_RETURN: begin
                    if (fcnt == FR_W'(RETURN_FRAMES - 1)) begin
                        done_d    = 1'b1;
                        done_id_d = active_id;
                        fcnt_d    = '0;
                        state_d   = S_IDLE;
                        // Chain straight into the next queued vend without an idle frame.
                        if (fifo_count != '0) begin
                            pop = 1'b1;
                            if (head_valid) begin
                                state_d  = S_VEND;
                                active_d = head_id;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end else begin
                        fcnt_d = fcnt + FR_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM state and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            fcnt       <= '0;
            active_id  <= '0;
            done_pulse <= 1'b0;
            done_id    <= '0;
            err_pulse  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            fcnt       <= fcnt_d;
            active_id  <= active_d;
            done_pulse <= done_d;
            done_id    <= done_id_d;
            err_pulse  <= err_d;
            busy       <= (state_d != S_IDLE);
        end
    end

    // Occupancy bookkeeping; push and pop together leave the count unchanged.
    always_comb begin
        count_d = fifo_count;
        case ({push, pop})
            2'b10:   count_d = fifo_count + CNT_W'(1);
            2'b01:   count_d = fifo_count - CNT_W'(1);
            default: count_d = fifo_count;
        endcase
    end

    // Frame counter, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            req_ready  <= 1'b1;
        end else begin
            frame_cnt  <= frame_end ? '0 : frame_cnt + FC_W'(1);
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_d;
            req_ready  <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    // Request storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_id;
        end
    end

    // Per-servo pulse width; state and active_id only move at frame boundaries.
    always_comb begin
        for (int i = 0; i < NUM_SERVOS; i++) begin
            pulse_w[i] = ((state == S_VEND) && (active_id == ID_W'(i))) ?
                         FC_W'(PULSE_VEND) : FC_W'(PULSE_HOME);
        end
    end

    // PWM outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            servo_out <= '0;
        end else begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                servo_out[i] <= (frame_cnt < pulse_w[i]);
            end
        end
    end

endmodule

// File: tb/tb_servo_dispense_scheduler.sv
module tb_servo_dispense_scheduler;
    localparam int NS  = 4;
    localparam int PER = 100;
    localparam int PH  = 5;
    localparam int PV  = 10;
    localparam int HF  = 2;
    localparam int RF  = 1;
    localparam int FD  = 4;
    localparam int ERR_TAG = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic [2:0]    req_id = 3'd0;
    logic          req_ready;
    logic [NS-1:0] servo_out;
    logic          busy;
    logic [2:0]    active_id;
    logic          done_pulse;
    logic [2:0]    done_id;
    logic          err_pulse;
    logic [2:0]    fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_fc    = 0;
    int cyc      = 0;
    int exp_q[$];
    int ev_log[$];
    int ev_cyc[$];
    int pw_log[$];
    int run_len[NS];
    int multi_pulse = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    servo_dispense_scheduler #(
        .NUM_SERVOS(NS), .PERIOD_CYCLES(PER), .PULSE_HOME(PH), .PULSE_VEND(PV),
        .HOLD_FRAMES(HF), .RETURN_FRAMES(RF), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_id(req_id),
        .req_ready(req_ready), .servo_out(servo_out), .busy(busy),
        .active_id(active_id), .done_pulse(done_pulse), .done_id(done_id),
        .err_pulse(err_pulse), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Independent model of the PWM frame position.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_fc <= 0;
        else      tb_fc <= (tb_fc == PER - 1) ? 0 : tb_fc + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records pulse widths and done/err events.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NS; i++) run_len[i] = 0;
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (servo_out[i]) run_len[i]++;
                else if (run_len[i] != 0) begin
                    pw_log.push_back(i * 1000 + run_len[i]);
                    run_len[i] = 0;
                end
            end
            if (done_pulse) begin
                ev_log.push_back(int'(done_id));
                ev_cyc.push_back(cyc);
            end
            if (err_pulse) ev_log.push_back(ERR_TAG);
            if ((done_pulse && prev_done) || (err_pulse && prev_err)) multi_pulse++;
            prev_done = done_pulse;
            prev_err  = err_pulse;
        end
    end

    task automatic goto_fc(input int p);
        for (int k = 0; k < 2 * PER; k++) begin
            @(posedge clk); #1;
            if (tb_fc == p) break;
        end
    endtask

    task automatic push_req(input int id, output bit acc);
        req_id    = 3'(id);
        req_valid = 1'b1;
        acc       = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (acc) exp_q.push_back((id < NS) ? id : ERR_TAG);
    endtask

    task automatic wait_events(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && ev_log.size() < n; k++) begin
            @(posedge clk); #1;
        end
        ok = (ev_log.size() >= n);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++; if (servo_out !== '0)  begin n_fail++; $display("FAIL reset_servo_out: got %b want 0", servo_out); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (active_id !== 3'd0) begin n_fail++; $display("FAIL reset_active_id: got %0d want 0", active_id); end
        n_checks++; if (done_pulse !== 1'b0 || done_id !== 3'd0) begin n_fail++; $display("FAIL reset_done: got %b/%0d want 0/0", done_pulse, done_id); end
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_pulse); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        rst = 1'b1;
        pw_log.delete();
        repeat (2 * PER + 10) @(posedge clk);
        #1;
        n_checks++; if (pw_log.size() < 2 * NS) begin n_fail++; $display("FAIL reset_pwm_count: got %0d pulses want >= %0d", pw_log.size(), 2 * NS); end
        foreach (pw_log[k]) begin
            n_checks++;
            if (pw_log[k] % 1000 != PH) begin n_fail++; $display("FAIL reset_pwm_width: servo %0d got %0d want %0d", pw_log[k] / 1000, pw_log[k] % 1000, PH); end
        end
    endtask

    task automatic test_single_vend;
        bit acc, ok;
        int k2, e, o;
        goto_fc(10);
        ev_log.delete(); pw_log.delete();
        push_req(2, acc);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", acc); end
        goto_fc(0);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        n_checks++; if (active_id !== 3'd2) begin n_fail++; $display("FAIL single_active_id: got %0d want 2", active_id); end
        wait_events(1, 4 * PER, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d events want 1", ev_log.size()); end
        n_checks++; if (busy !== 1'b0 || done_pulse !== 1'b0) begin n_fail++; $display("FAIL single_after_done: got busy=%b done=%b want 0/0", busy, done_pulse); end
        while (exp_q.size() > 0 && ev_log.size() > 0) begin
            e = exp_q.pop_front(); o = ev_log.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_event: got %0d want %0d", o, e); end
        end
        repeat (PER + 10) @(posedge clk);
        #1;
        k2 = 0;
        foreach (pw_log[k]) begin
            n_checks++;
            if (pw_log[k] / 1000 == 2) begin
                if (pw_log[k] % 1000 != ((k2 < HF) ? PV : PH)) begin n_fail++; $display("FAIL single_pwm_s2: pulse %0d got %0d want %0d", k2, pw_log[k] % 1000, (k2 < HF) ? PV : PH); end
                k2++;
            end else if (pw_log[k] % 1000 != PH) begin
                n_fail++; $display("FAIL single_pwm_other: servo %0d got %0d want %0d", pw_log[k] / 1000, pw_log[k] % 1000, PH);
            end
        end
        n_checks++; if (k2 < HF + RF) begin n_fail++; $display("FAIL single_pwm_s2_count: got %0d want >= %0d", k2, HF + RF); end
    endtask

    task automatic test_queue_full;
        bit acc, ok;
        int e, o;
        ev_log.delete(); ev_cyc.delete();
        goto_fc(10);
        push_req(3, acc);
        goto_fc(0);
        goto_fc(10);
        push_req(0, acc); push_req(1, acc); push_req(2, acc); push_req(3, acc);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", req_ready); end
        push_req(0, acc);
        n_checks++; if (acc !== 1'b0 || fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_reject: got acc=%b count=%0d want 0/4", acc, fifo_count); end
        wait_events(5, 20 * PER, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout: got %0d events want 5", ev_log.size()); end
        while (exp_q.size() > 0 && ev_log.size() > 0) begin
            e = exp_q.pop_front(); o = ev_log.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_event: got %0d want %0d", o, e); end
        end
        for (int k = 1; k < ev_cyc.size(); k++) begin
            n_checks++;
            if (ev_cyc[k] - ev_cyc[k-1] != (HF + RF) * PER) begin n_fail++; $display("FAIL full_gap: done %0d got %0d cycles want %0d", k, ev_cyc[k] - ev_cyc[k-1], (HF + RF) * PER); end
        end
        n_checks++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_drain: got count=%0d busy=%b want 0/0", fifo_count, busy); end
    endtask

    task automatic test_invalid_id;
        bit acc;
        int e, o;
        ev_log.delete();
        goto_fc(10);
        pw_log.delete();
        push_req(5, acc);
        n_checks++; if (acc !== 1'b1 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL inv_push: got acc=%b count=%0d want 1/1", acc, fifo_count); end
        goto_fc(0);
        @(negedge clk);
        n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL inv_err: got %b want 1", err_pulse); end
        n_checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL inv_state: got busy=%b count=%0d want 0/0", busy, fifo_count); end
        @(negedge clk);
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL inv_err_width: got %b want 0", err_pulse); end
        @(posedge clk); #1;
        n_checks++; if (ev_log.size() != 1) begin n_fail++; $display("FAIL inv_event_count: got %0d want 1", ev_log.size()); end
        while (exp_q.size() > 0 && ev_log.size() > 0) begin
            e = exp_q.pop_front(); o = ev_log.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL inv_event: got %0d want %0d", o, e); end
        end
        repeat (PER) @(posedge clk);
        #1;
        foreach (pw_log[k]) begin
            n_checks++;
            if (pw_log[k] % 1000 != PH) begin n_fail++; $display("FAIL inv_pwm: servo %0d got %0d want %0d", pw_log[k] / 1000, pw_log[k] % 1000, PH); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL inv_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_simul_push_pop;
        bit acc, ok;
        int e, o;
        ev_log.delete();
        goto_fc(10);
        push_req(2, acc);
        goto_fc(PER - 1);
        push_req(1, acc);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL pp_accept: got %b want 1", acc); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL pp_count: got %0d want 1", fifo_count); end
        n_checks++; if (busy !== 1'b1 || active_id !== 3'd2) begin n_fail++; $display("FAIL pp_active: got busy=%b id=%0d want 1/2", busy, active_id); end
        wait_events(2, 8 * PER, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pp_timeout: got %0d events want 2", ev_log.size()); end
        while (exp_q.size() > 0 && ev_log.size() > 0) begin
            e = exp_q.pop_front(); o = ev_log.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL pp_event: got %0d want %0d", o, e); end
        end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL pp_drain: got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_mid_vend;
        bit acc;
        ev_log.delete();
        goto_fc(10);
        push_req(0, acc);
        push_req(1, acc);
        goto_fc(0);
        goto_fc(3);
        n_checks++; if (servo_out[0] !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rmv_pre: got s0=%b busy=%b want 1/1", servo_out[0], busy); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (servo_out !== '0) begin n_fail++; $display("FAIL rmv_servo_out: got %b want 0", servo_out); end
        n_checks++; if (busy !== 1'b0 || fifo_count !== 3'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rmv_state: got busy=%b count=%0d ready=%b want 0/0/1", busy, fifo_count, req_ready); end
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4 * PER) @(posedge clk);
        #1;
        n_checks++; if (ev_log.size() != 0) begin n_fail++; $display("FAIL rmv_no_done: got %0d events want 0", ev_log.size()); end
        n_checks++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmv_after: got count=%0d busy=%b want 0/0", fifo_count, busy); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_vend();
        test_queue_full();
        test_invalid_id();
        test_simul_push_pop();
        test_reset_mid_vend();
        n_checks++; if (multi_pulse != 0) begin n_fail++; $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", multi_pulse); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_dispense_scheduler.md
Name: servo_dispense_scheduler

Overview:
- Shares a bank of dispense servos between vend requests from the vending FSM.
- Queues requests in a small FIFO and runs exactly one servo vend cycle at a time: rotate to vend position, hold, return home.
- Generates aligned 50 Hz PWM for every servo. Idle servos are held at the home pulse.
- Sits between the vend/payment FSM and the servo output pins.

Parameters:
- NUM_SERVOS, 4, number of servo channels (1..8).
- PERIOD_CYCLES, 1000000, PWM frame length in clk cycles (20 ms at 50 MHz).
- PULSE_HOME, 50000, home-position pulse width in cycles (1 ms).
- PULSE_VEND, 100000, vend-position pulse width in cycles (2 ms); must be less than PERIOD_CYCLES.
- HOLD_FRAMES, 25, frames spent at the vend position (0.5 s); must be at least 1.
- RETURN_FRAMES, 25, frames spent at home before done is reported; must be at least 1.
- FIFO_DEPTH, 4, request queue depth (power of 2).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  vend request present.
- req_id  in  3  servo index to actuate.
- req_ready  out  1  high when FIFO not full.
- servo_out  out  NUM_SERVOS  registered PWM, one bit per servo.
- busy  out  1  high in VEND or RETURN.
- active_id  out  3  servo currently being sequenced; holds last value when idle.
- done_pulse  out  1  one-cycle strobe at end of a vend cycle.
- done_id  out  3  servo index qualified by done_pulse.
- err_pulse  out  1  one-cycle strobe when a popped req_id >= NUM_SERVOS is discarded.
- fifo_count  out  3  queued requests, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): frame_cnt=0, FIFO flushed, state=IDLE. All of the following are 0: servo_out, busy, active_id, done_pulse, done_id, err_pulse, fifo_count. req_ready=1.
- Reset mid-operation aborts the vend immediately. No done_pulse is issued.
- frame_cnt counts 0..PERIOD_CYCLES-1 and wraps. The frame boundary is the cycle where frame_cnt==PERIOD_CYCLES-1.
- Per-servo width: PULSE_VEND for active_id while in VEND; otherwise PULSE_HOME.
- servo_out[i] is registered as (frame_cnt < width_i), so there is one cycle of latency.
  - Each frame's high time is exactly width_i cycles.
  - Width changes only at frame boundaries, so a pulse is never truncated or stretched.
- Push: accepted when req_valid && req_ready.
- Pop: occurs only at a frame boundary, when state is IDLE (or RETURN finishing) and fifo_count>0.
- Push and pop in the same cycle are both honoured; fifo_count is unchanged.
- A push while full is not accepted, because req_ready=0.
- FSM, all transitions at frame boundaries only:
  - IDLE: if fifo_count>0, pop.
    - Valid id: go to VEND, active_id=id, frame counter fcnt=0.
    - Invalid id: err_pulse=1, stay IDLE.
  - VEND: fcnt++. At HOLD_FRAMES frames, go to RETURN with fcnt=0.
  - RETURN: fcnt++. At RETURN_FRAMES frames, done_pulse=1 and done_id=active_id.
    - If the FIFO is non-empty, pop in the same cycle. A valid id goes straight to VEND (back-to-back vends); an invalid id gives err_pulse and IDLE.
    - Otherwise go to IDLE.
- busy=1 in VEND and RETURN only.
- done_pulse and err_pulse are never high for more than one cycle.
- A request for the servo that is currently active is queued and serviced normally after RETURN.
- FIFO pointers wrap modulo FIFO_DEPTH.
- fifo_count is exact at full and empty, with no overflow or underflow.

Test Plan (PERIOD_CYCLES=100, PULSE_HOME=5, PULSE_VEND=10, HOLD_FRAMES=2, RETURN_FRAMES=1, NUM_SERVOS=4, FIFO_DEPTH=4):
- Reset: hold rst=0 for 5 cycles -> all outputs 0 and req_ready=1. After release, every servo_out bit pulses high 5 cycles in every 100.
- Single vend: push id 2 -> at the next boundary busy=1. servo_out[2] is 10 cycles high for 2 frames, then 5 cycles high for 1 frame. done_pulse fires once with done_id=2; busy=0 after it. Other bits stay 5 high.
- Queue full: push ids 0,1,2,3,0 on consecutive cycles while busy -> fourth push sets fifo_count=4 and req_ready=0, fifth is rejected. Servos 0,1,2,3 then run back-to-back with no idle frame, giving 4 done_pulses.
- Invalid id: push id 5 -> at the boundary err_pulse=1 for 1 cycle, no servo enters vend width, busy stays 0, fifo_count returns to 0.
- Simultaneous push/pop: push id 1 in the boundary cycle where a pop occurs with fifo_count=1 -> fifo_count stays 1, and id 1 runs next.
- Reset mid-vend: assert rst during a VEND frame -> servo_out=0 within the same cycle, the FIFO is empty after release, and no done_pulse is issued.
